// File: rtl/fft_frame_arbiter_if.sv
// FIFO-side, FFT-side and status signals of the FFT frame arbiter.
// The master modport is the arbiter; slave is its environment.
interface fft_frame_arbiter_if #(
    parameter int DATA_W = 48,
    parameter int CNT_W  = 13
);
    logic [DATA_W-1:0] S0_DOUT;
    logic              S0_EMPTY;
    logic [CNT_W-1:0]  S0_COUNT;
    logic              S0_RD_EN;
    logic              S0_DIR;
    logic [DATA_W-1:0] S1_DOUT;
    logic              S1_EMPTY;
    logic [CNT_W-1:0]  S1_COUNT;
    logic              S1_RD_EN;
    logic              S1_DIR;
    logic [DATA_W-1:0] M_TDATA;
    logic              M_TVALID;
    logic              M_TREADY;
    logic              M_TLAST;
    logic              M_TUSER;
    logic [7:0]        CFG_TDATA;
    logic              CFG_TVALID;
    logic              CFG_TREADY;
    logic [1:0]        GRANT;
    logic              FRAME_DONE;
    logic              STALL_ERR;

    modport master (
        input  S0_DOUT, S0_EMPTY, S0_COUNT, S0_DIR,
        input  S1_DOUT, S1_EMPTY, S1_COUNT, S1_DIR,
        input  M_TREADY, CFG_TREADY,
        output S0_RD_EN, S1_RD_EN,
        output M_TDATA, M_TVALID, M_TLAST, M_TUSER,
        output CFG_TDATA, CFG_TVALID,
        output GRANT, FRAME_DONE, STALL_ERR
    );

    modport slave (
        output S0_DOUT, S0_EMPTY, S0_COUNT, S0_DIR,
        output S1_DOUT, S1_EMPTY, S1_COUNT, S1_DIR,
        output M_TREADY, CFG_TREADY,
        input  S0_RD_EN, S1_RD_EN,
        input  M_TDATA, M_TVALID, M_TLAST, M_TUSER,
        input  CFG_TDATA, CFG_TVALID,
        input  GRANT, FRAME_DONE, STALL_ERR
    );
endinterface

// File: rtl/fft_frame_arbiter.sv
// Shares one FFT/IFFT core between two FWFT sample FIFOs,
// one config word plus one whole frame per grant.
module fft_frame_arbiter #(
    parameter int DATA_W    = 48,
    parameter int FRAME_LEN = 512,
    parameter int CNT_W     = 13,
    parameter int STALL_MAX = 4096
) (
    input  logic                SYS_CLK,
    input  logic                SYS_RSTN,
    fft_frame_arbiter_if.master bus
);
    localparam int BW = $clog2(FRAME_LEN);
    localparam int SW = $clog2(STALL_MAX + 1);

    typedef enum logic [1:0] {IDLE, CFG, READ, DONE} state_t;

    state_t            state;
    logic [1:0]        grant;
    logic              chan;
    logic              cfg_dir;
    logic              cfg_valid;
    logic              last_grant;
    logic              frame_done;
    logic              stall_err;
    logic [BW-1:0]     beat_cnt;
    logic [SW-1:0]     stall_cnt;

    logic              elig0;
    logic              elig1;
    logic              pick1;
    logic              in_read;
    logic              src_empty;
    logic [DATA_W-1:0] src_dout;
    logic              m_valid;
    logic              accept;
    logic              is_last;

    assign elig0     = bus.S0_COUNT >= CNT_W'(FRAME_LEN);
    assign elig1     = bus.S1_COUNT >= CNT_W'(FRAME_LEN);
    // ch1 wins when alone, or on a tie when ch0 went last
    assign pick1     = elig1 && (!elig0 || !last_grant);
    assign in_read   = state == READ;
    assign src_empty = chan ? bus.S1_EMPTY : bus.S0_EMPTY;
    assign src_dout  = chan ? bus.S1_DOUT : bus.S0_DOUT;
    assign m_valid   = in_read && !src_empty;
    assign accept    = m_valid && bus.M_TREADY;
    assign is_last   = beat_cnt == BW'(FRAME_LEN - 1);

    assign bus.M_TVALID   = m_valid;
    assign bus.M_TDATA    = in_read ? src_dout : '0;
    assign bus.M_TLAST    = m_valid && is_last;
    assign bus.M_TUSER    = chan;
    assign bus.S0_RD_EN   = accept && !chan;
    assign bus.S1_RD_EN   = accept && chan;
    assign bus.CFG_TDATA  = {7'b0, cfg_dir};
    assign bus.CFG_TVALID = cfg_valid;
    assign bus.GRANT      = grant;
    assign bus.FRAME_DONE = frame_done;
    assign bus.STALL_ERR  = stall_err;

    always_ff @(posedge SYS_CLK or negedge SYS_RSTN) begin
        if (!SYS_RSTN) begin
            state      <= IDLE;
            grant      <= 2'b00;
            chan       <= 1'b0;
            cfg_dir    <= 1'b0;
            cfg_valid  <= 1'b0;
            last_grant <= 1'b1;
            frame_done <= 1'b0;
            beat_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (elig0 || elig1) begin
                        grant     <= pick1 ? 2'b10 : 2'b01;
                        chan      <= pick1;
                        cfg_dir   <= pick1 ? bus.S1_DIR : bus.S0_DIR;
                        cfg_valid <= 1'b1;
                        state     <= CFG;
                    end
                end
                CFG: begin
                    if (bus.CFG_TREADY) begin
                        cfg_valid <= 1'b0;
                        state     <= READ;
                    end
                end
                READ: begin
                    if (accept && is_last) begin
                        beat_cnt   <= '0;
                        grant      <= 2'b00;
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
                    last_grant <= chan;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Watchdog counts consecutive refused beats; the error stays until reset
    always_ff @(posedge SYS_CLK or negedge SYS_RSTN) begin
        if (!SYS_RSTN) begin
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else if (!in_read || accept) begin
            stall_cnt <= '0;
        end else if (m_valid) begin
            if (stall_cnt != SW'(STALL_MAX))
                stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt == SW'(STALL_MAX - 1))
                stall_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Randomised bench for fft_frame_arbiter: FIFO models, frame-level
// arbitration model and a scoreboard monitor on the FFT side.
module tb_fft_frame_arbiter;
    localparam int DW = 48;
    localparam int FL = 512;
    localparam int CW = 13;
    localparam int SM = 4096;

    typedef logic [DW-1:0] word_t;
    typedef struct packed {
        logic ch;
        logic dir;
    } frm_t;

    logic SYS_CLK = 1'b0;
    logic SYS_RSTN = 1'b0;
    always #5 SYS_CLK = ~SYS_CLK;

    fft_frame_arbiter_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    fft_frame_arbiter #(
        .DATA_W(DW), .FRAME_LEN(FL), .CNT_W(CW), .STALL_MAX(SM)
    ) dut (
        .SYS_CLK(SYS_CLK),
        .SYS_RSTN(SYS_RSTN),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FWFT FIFO models; contents only change at the clock edge
    word_t fq[2][$];
    word_t pend[2][$];
    bit    hide[2];
    int    rd_cnt[2];

    always @(posedge SYS_CLK) begin
        if (bus.S0_RD_EN && fq[0].size() > 0) begin
            void'(fq[0].pop_front());
            rd_cnt[0]++;
        end
        if (bus.S1_RD_EN && fq[1].size() > 0) begin
            void'(fq[1].pop_front());
            rd_cnt[1]++;
        end
        while (pend[0].size() > 0) fq[0].push_back(pend[0].pop_front());
        while (pend[1].size() > 0) fq[1].push_back(pend[1].pop_front());
        bus.S0_DOUT  <= fq[0].size() > 0 ? fq[0][0] : '0;
        bus.S0_EMPTY <= fq[0].size() == 0 || hide[0];
        bus.S0_COUNT <= CW'(fq[0].size());
        bus.S1_DOUT  <= fq[1].size() > 0 ? fq[1][0] : '0;
        bus.S1_EMPTY <= fq[1].size() == 0 || hide[1];
        bus.S1_COUNT <= CW'(fq[1].size());
    end

    // Reference model: whole frames, sample counts and round robin
    frm_t  exp_frames[$];
    word_t exp_data[2][$];
    int    mc[2];
    bit    mlg;
    bit    dir_m[2];

    function automatic void plan();
        bit c;
        while (mc[0] >= FL || mc[1] >= FL) begin
            if (mc[0] >= FL && mc[1] >= FL) c = !mlg;
            else c = mc[1] >= FL;
            exp_frames.push_back('{ch: c, dir: dir_m[c]});
            mc[c] -= FL;
            mlg = c;
        end
    endfunction

    task automatic load(input int ch, input int n);
        logic [63:0] r;
        for (int i = 0; i < n; i++) begin
            r = {$urandom(), $urandom()};
            pend[ch].push_back(r[DW-1:0]);
            exp_data[ch].push_back(r[DW-1:0]);
        end
        mc[ch] += n;
    endtask

    // Scoreboard monitor
    bit    in_frame;
    bit    cur_ch;
    bit    fd_exp;
    bit    tl_acc;
    int    beat;
    int    fd_cnt;
    frm_t  mf;
    word_t me;

    always @(negedge SYS_CLK) begin
        #2;
        if (!SYS_RSTN) begin
            in_frame = 0;
            fd_exp = 0;
            beat = 0;
        end else begin
            tl_acc = 0;
            if (fd_exp || bus.FRAME_DONE)
                check("frame_done", bus.FRAME_DONE, fd_exp);
            if (bus.FRAME_DONE) fd_cnt++;
            if (bus.CFG_TVALID && bus.CFG_TREADY) begin
                if (exp_frames.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL cfg_unexpected: got ch%0d expected none",
                             bus.M_TUSER);
                end else begin
                    mf = exp_frames.pop_front();
                    check("cfg_word", bus.CFG_TDATA, {7'b0, mf.dir});
                    check("cfg_grant", bus.GRANT, mf.ch ? 2'b10 : 2'b01);
                    cur_ch = mf.ch;
                    in_frame = 1;
                    beat = 0;
                end
            end
            if (bus.M_TVALID && bus.M_TREADY) begin
                if (!in_frame) begin
                    total++;
                    bad++;
                    $display("FAIL stray_beat: got %0h expected none",
                             bus.M_TDATA);
                end else begin
                    me = exp_data[cur_ch].size() > 0 ?
                         exp_data[cur_ch].pop_front() : '0;
                    check("beat_data", bus.M_TDATA, me);
                    check("beat_tuser", bus.M_TUSER, cur_ch);
                    check("beat_tlast", bus.M_TLAST, beat == FL - 1);
                    beat++;
                    if (beat == FL) begin
                        in_frame = 0;
                        tl_acc = 1;
                    end
                end
            end
            fd_exp = tl_acc;
        end
    end

    task automatic wait_idle(input string name, input bit rnd);
        int n = 0;
        while ((exp_frames.size() != 0 || in_frame || fd_exp) && n < 20000) begin
            @(negedge SYS_CLK);
            if (rnd) bus.M_TREADY = 1'($urandom_range(0, 1));
            n++;
        end
        bus.M_TREADY = 1'b1;
        repeat (3) @(negedge SYS_CLK);
        check({name, "_timeout"}, n >= 20000, 0);
    endtask

    task automatic check_rst(input string name);
        check({name, "_data"}, bus.M_TDATA, 0);
        check({name, "_ctrl"},
              {bus.GRANT, bus.CFG_TVALID, bus.CFG_TDATA, bus.M_TVALID,
               bus.M_TLAST, bus.M_TUSER, bus.S0_RD_EN, bus.S1_RD_EN,
               bus.FRAME_DONE, bus.STALL_ERR}, 0);
    endtask

    task automatic set_dir(input int ch, input bit d);
        dir_m[ch] = d;
        if (ch == 0) bus.S0_DIR = d;
        else bus.S1_DIR = d;
    endtask

    task automatic wait_pops(input int ch, input int base, input int k);
        int n = 0;
        while (rd_cnt[ch] - base < k && n < 5000) begin
            @(negedge SYS_CLK);
            n++;
        end
        check("wait_pops_timeout", n >= 5000, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    int    base;
    int    fdb;
    int    errs;
    int    lows;
    int    n;
    word_t held;

    initial begin
        bus.M_TREADY = 1'b1;
        bus.CFG_TREADY = 1'b1;
        set_dir(0, 0);
        set_dir(1, 0);
        mlg = 1;
        repeat (3) @(negedge SYS_CLK);
        #1 check_rst("reset");
        @(negedge SYS_CLK);
        SYS_RSTN = 1'b1;
        repeat (5) @(negedge SYS_CLK);
        #1 check("idle_grant", bus.GRANT, 0);
        check("idle_cfg_valid", bus.CFG_TVALID, 0);

        // single channel, 600 samples
        base = rd_cnt[0];
        fdb = fd_cnt;
        load(0, 600);
        plan();
        wait_idle("t1", 0);
        check("t1_rd_en_cycles", rd_cnt[0] - base, FL);
        check("t1_frame_done_pulses", fd_cnt - fdb, 1);
        check("t1_ch0_left", fq[0].size(), 88);

        // reset so the next tie starts from the reset round-robin state
        @(negedge SYS_CLK);
        SYS_RSTN = 1'b0;
        mlg = 1;
        repeat (2) @(negedge SYS_CLK);
        SYS_RSTN = 1'b1;

        // both channels full: alternating frames, ch1 inverse
        set_dir(1, 1);
        load(0, 1024);
        load(1, 1024);
        plan();
        wait_idle("t2", 0);
        check("t2_ch0_left", fq[0].size(), 88);
        check("t2_ch1_left", fq[1].size(), 0);

        // random backpressure
        load(0, 512);
        plan();
        wait_idle("t3", 1);

        // config held off for 20 cycles
        bus.CFG_TREADY = 1'b0;
        load(1, 512);
        plan();
        n = 0;
        do begin
            @(negedge SYS_CLK);
            #1 n++;
        end while (!bus.CFG_TVALID && n < 50);
        check("t4_cfg_valid_seen", bus.CFG_TVALID, 1);
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge SYS_CLK);
            #1;
            if (!bus.CFG_TVALID || bus.CFG_TDATA != 8'h01 ||
                bus.S0_RD_EN || bus.S1_RD_EN) errs++;
        end
        check("t4_cfg_hold_errs", errs, 0);
        bus.CFG_TREADY = 1'b1;
        wait_idle("t4", 0);

        // ch0 runs empty for 50 cycles mid-frame
        base = rd_cnt[0];
        load(0, 512);
        plan();
        wait_pops(0, base, 299);
        hide[0] = 1;
        lows = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge SYS_CLK);
            #1;
            if (!bus.M_TVALID) lows++;
        end
        hide[0] = 0;
        check("t5_valid_low_cycles", lows, 50);
        @(negedge SYS_CLK);
        #1 check("t5_resume_valid", bus.M_TVALID, 1);
        wait_idle("t5", 0);
        check("t5_beats", rd_cnt[0] - base, FL);

        // stall watchdog, then reset mid-frame
        base = rd_cnt[0];
        load(0, 724);
        plan();
        wait_pops(0, base, 100);
        bus.M_TREADY = 1'b0;
        #1 held = bus.M_TDATA;
        repeat (SM - 1) @(negedge SYS_CLK);
        #1 check("t6_stall_err_early", bus.STALL_ERR, 0);
        check("t6_held_data", bus.M_TDATA, held);
        check("t6_held_valid", bus.M_TVALID, 1);
        @(negedge SYS_CLK);
        #1 check("t6_stall_err_set", bus.STALL_ERR, 1);
        bus.M_TREADY = 1'b1;
        repeat (10) @(negedge SYS_CLK);
        #1 check("t6_stall_err_sticky", bus.STALL_ERR, 1);
        @(negedge SYS_CLK);
        SYS_RSTN = 1'b0;
        #1 check_rst("t6_midframe_reset");
        exp_frames.delete();
        mc[0] = fq[0].size();
        mlg = 1;
        repeat (3) @(negedge SYS_CLK);
        SYS_RSTN = 1'b1;
        plan();
        wait_idle("t6", 0);
        check("t6_stall_err_cleared", bus.STALL_ERR, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
